// File: rtl/cmip_hs_pkg.sv
// Shared types and defaults for the 4-phase req/ack source-side controller.
package cmip_hs_pkg;

   // Handshake phases, as seen from the source domain.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      REL  = 2'd2
   } hs_state_e;

   // Default depth of the ack resynchronizer.
   localparam int SYNC_N_DEF = 2;

endpackage

// File: rtl/cmip_dff_sync.sv
// N-flop resynchronizer for a single asynchronous level into the clk domain.
module cmip_dff_sync #(
   parameter int   N         = 2,
   parameter logic RST_VALUE = 1'b0
) (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q
);

   logic [N-1:0] sync_q;

   // Shift the async level through the chain; the last flop is the safe copy.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) sync_q <= {N{RST_VALUE}};
      else       sync_q <= {sync_q[N-2:0], d};
   end

   assign q = sync_q[N-1];

endmodule

// File: rtl/cmip_hs_sync_tx.sv
// Source-side controller for a 4-phase req/ack clock-domain crossing.
// Accepts one word on valid/ready, holds it on data_o, raises req_o and
// waits for the resynchronized ack to rise and fall before taking the next.
// A sticky error flags any phase that outlasts TIMEOUT_CYC; the FSM keeps
// waiting regardless so the protocol never gets out of step.
module cmip_hs_sync_tx
   import cmip_hs_pkg::*;
#(
   parameter int DW          = 32,
   parameter int SYNC_N      = SYNC_N_DEF,
   parameter int TO_W        = 16,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          req_o,
   output logic [DW-1:0] data_o,
   input  logic          ack_i,
   output logic          done,
   output logic          busy,
   output logic          timeout_err,
   input  logic          err_clr
);

   // Last counter value allowed before a phase is declared late.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   localparam bit              TO_EN   = (TIMEOUT_CYC != 0);

   hs_state_e       state, state_nx;
   logic            ack_s;
   logic            req_nx;
   logic [DW-1:0]   data_nx;
   logic [TO_W-1:0] cnt, cnt_nx, cnt_inc;
   logic            done_nx;
   logic            err_nx;
   logic            to_hit;

   cmip_dff_sync #(
      .N         (SYNC_N),
      .RST_VALUE (1'b0)
   ) u_ack_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    (ack_i),
      .q    (ack_s)
   );

   // A stale-high ack (after reset or a stuck destination) keeps us from
   // starting a new request until the destination has released it.
   assign in_ready = (state == IDLE) & ~ack_s;
   assign busy     = (state != IDLE);

   assign cnt_inc = (cnt == '1) ? cnt : cnt + TO_W'(1);
   assign to_hit  = TO_EN && (cnt == TO_LAST);

   // Next-state, outputs and timeout bookkeeping for the handshake.
   always_comb begin
      state_nx = state;
      req_nx   = req_o;
      data_nx  = data_o;
      cnt_nx   = cnt;
      done_nx  = 1'b0;
      err_nx   = timeout_err & ~err_clr;
      case (state)
         IDLE: begin
            req_nx = 1'b0;
            if (in_valid && in_ready) begin
               data_nx  = in_data;
               req_nx   = 1'b1;
               state_nx = REQ;
               cnt_nx   = '0;
            end
         end
         REQ: begin
            if (ack_s) begin
               req_nx   = 1'b0;
               state_nx = REL;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt_inc;
               if (to_hit) err_nx = 1'b1;
            end
         end
         REL: begin
            if (!ack_s) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end else begin
               cnt_nx = cnt_inc;
               if (to_hit) err_nx = 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            req_nx   = 1'b0;
         end
      endcase
   end

   // Register state, the held word, the request line and status flags.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         req_o       <= 1'b0;
         data_o      <= '0;
         cnt         <= '0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nx;
         req_o       <= req_nx;
         data_o      <= data_nx;
         cnt         <= cnt_nx;
         done        <= done_nx;
         timeout_err <= err_nx;
      end
   end

endmodule

// File: tb/tb_cmip_hs_sync_tx.sv
// Scoreboarded bench for cmip_hs_sync_tx: accepted words are queued as they
// are offered, and a monitor pops them when req_o rises and checks data_o.
module tb_cmip_hs_sync_tx;

   localparam int DW     = 32;
   localparam int SYNC_N = 2;
   localparam int TO_CYC = 8;

   logic          clk;
   logic          rstn;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          req_o;
   logic [DW-1:0] data_o;
   logic          ack_i;
   logic          done;
   logic          busy;
   logic          timeout_err;
   logic          err_clr;

   // Destination model: either a manual level or an auto responder.
   bit   auto_ack;
   bit   ack_rand;
   logic ack_man;
   logic ack_auto;
   int   cd;

   assign ack_i = auto_ack ? ack_auto : ack_man;

   int n_chk;
   int n_err;
   int n_done;
   int n_acc;
   logic [DW-1:0] exp_q[$];

   cmip_hs_sync_tx #(
      .DW          (DW),
      .SYNC_N      (SYNC_N),
      .TO_W        (16),
      .TIMEOUT_CYC (TO_CYC)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .req_o       (req_o),
      .data_o      (data_o),
      .ack_i       (ack_i),
      .done        (done),
      .busy        (busy),
      .timeout_err (timeout_err),
      .err_clr     (err_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chkn(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer a word until it is taken; returns just after the accepting edge.
   task automatic send(input logic [DW-1:0] w);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = w;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         step();
      end
      in_valid = 1'b0;
      chk1("send_accepted", ok, 1'b1);
   endtask

   task automatic wait_req_low();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = !req_o;
         step();
      end
      chk1("req_fall_seen", ok, 1'b1);
   endtask

   task automatic wait_done();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = done;
         step();
      end
      chk1("done_seen", ok, 1'b1);
   endtask

   task automatic finish_hs();
      ack_man = 1'b1;
      wait_req_low();
      ack_man = 1'b0;
      wait_done();
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = !busy && (exp_q.size() == 0);
         step();
      end
      chk1("drain_idle", ok, 1'b1);
   endtask

   // Auto destination: follows req_o after a short (fixed or random) delay.
   initial begin
      ack_auto = 1'b0;
      cd       = 1;
      forever begin
         @(negedge clk);
         if (auto_ack && ack_auto != req_o) begin
            if (cd == 0) begin
               ack_auto = req_o;
               cd = ack_rand ? int'($urandom_range(0, 3)) : 1;
            end else begin
               cd--;
            end
         end
      end
   end

   // Record every word that will be accepted at the coming edge.
   always @(negedge clk) begin
      if (rstn && in_valid && in_ready) begin
         exp_q.push_back(in_data);
         n_acc++;
      end
   end

   // Monitor: word order and integrity, hold stability, ready gating, done shape.
   logic          req_prev;
   logic          done_prev;
   logic [DW-1:0] held;
   initial begin
      req_prev  = 1'b0;
      done_prev = 1'b0;
      held      = '0;
   end
   always @(negedge clk) begin
      if (rstn) begin
         if (req_o && !req_prev) begin
            if (exp_q.size() == 0) chk1("req_without_accept", 1'b1, 1'b0);
            else                   chk32("data_o_at_req", data_o, exp_q.pop_front());
            held = data_o;
         end else if (req_o) begin
            chk32("data_o_stable", data_o, held);
         end
         if (busy) chk1("in_ready_while_busy", in_ready, 1'b0);
         if (done) begin
            n_done++;
            chk1("done_single_pulse", done_prev, 1'b0);
         end
      end
      req_prev  = req_o;
      done_prev = done;
   end

   logic [DW-1:0] w3 [3];

   initial begin
      int start;
      int sent;
      n_chk = 0; n_err = 0; n_done = 0; n_acc = 0;
      rstn = 1'b0; in_valid = 1'b0; in_data = '0; err_clr = 1'b0;
      auto_ack = 1'b0; ack_rand = 1'b0; ack_man = 1'b0;
      w3[0] = 32'h1; w3[1] = 32'h2; w3[2] = 32'h3;

      // Reset state
      repeat (2) @(negedge clk);
      chk1 ("rst_req_o", req_o, 1'b0);
      chk32("rst_data_o", data_o, '0);
      chk1 ("rst_done", done, 1'b0);
      chk1 ("rst_busy", busy, 1'b0);
      chk1 ("rst_err", timeout_err, 1'b0);
      chk1 ("rst_in_ready", in_ready, 1'b1);
      step();
      rstn = 1'b1;
      step();

      // Basic transfer with fixed ack timing
      send(32'hDEADBEEF);
      for (int n = 1; n <= 13; n++) begin
         ack_man = (n >= 3 && n < 8);
         @(negedge clk);
         chk1("basic_req", req_o, (n >= 1 && n <= 3 + SYNC_N));
         chk1("basic_done", done, (n == 8 + SYNC_N + 1));
         chk1("basic_in_ready", in_ready, (n >= 8 + SYNC_N + 1));
         chk1("basic_busy", busy, (n <= 8 + SYNC_N));
         step();
      end

      // Back-to-back with valid held and a 1-cycle responder
      auto_ack = 1'b1; ack_rand = 1'b0;
      start = n_done;
      sent  = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && sent < 3; i++) begin
         in_data = w3[sent];
         @(negedge clk);
         if (in_ready) sent++;
         step();
      end
      in_valid = 1'b0;
      drain();
      chkn("b2b_done_count", n_done - start, 3);

      // Randomized traffic with random responder delays
      ack_rand = 1'b1;
      start = n_done;
      sent  = 0;
      for (int i = 0; i < 3000 && sent < 30; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = $urandom;
         @(negedge clk);
         if (in_valid && in_ready) sent++;
         step();
      end
      in_valid = 1'b0;
      drain();
      chkn("rand_done_count", n_done - start, 30);
      chkn("rand_queue_empty", exp_q.size(), 0);
      chk1("rand_no_timeout", timeout_err, 1'b0);
      auto_ack = 1'b0;

      // Stale ack held through reset release
      ack_man = 1'b1;
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      repeat (3) step();
      in_valid = 1'b1;
      in_data  = 32'hA5A5A5A5;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         chk1("stale_in_ready", in_ready, 1'b0);
         chk1("stale_req", req_o, 1'b0);
         step();
      end
      ack_man = 1'b0;
      for (int n = 0; n <= SYNC_N; n++) begin
         @(negedge clk);
         chk1("stale_release_ready", in_ready, (n == SYNC_N));
         step();
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk1("stale_then_req", req_o, 1'b1);
      step();
      finish_hs();

      // Timeout with ack stuck low
      send(32'h0BADF00D);
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         chk1("to_err", timeout_err, (n >= TO_CYC + 1));
         chk1("to_req_held", req_o, 1'b1);
         step();
      end
      finish_hs();
      chk1("to_err_sticky", timeout_err, 1'b1);
      err_clr = 1'b1;
      @(negedge clk);
      chk1("to_err_before_clr_edge", timeout_err, 1'b1);
      step();
      err_clr = 1'b0;
      @(negedge clk);
      chk1("to_err_cleared", timeout_err, 1'b0);
      step();

      // Set and clear on the same edge: set wins
      send(32'h00005EED);
      for (int n = 1; n <= 11; n++) begin
         err_clr = (n == TO_CYC || n == TO_CYC + 2);
         @(negedge clk);
         if (n == TO_CYC)                     chk1("coll_err_pre", timeout_err, 1'b0);
         if (n == TO_CYC + 1 || n == TO_CYC + 2) chk1("coll_set_wins", timeout_err, 1'b1);
         if (n == TO_CYC + 3)                 chk1("coll_clr_after", timeout_err, 1'b0);
         step();
      end
      err_clr = 1'b0;
      finish_hs();

      // Asynchronous reset while requesting
      send(32'h12345678);
      @(negedge clk);
      chk1("mid_req_high", req_o, 1'b1);
      #2 rstn = 1'b0;
      #1;
      chk1 ("mid_rst_req", req_o, 1'b0);
      chk1 ("mid_rst_busy", busy, 1'b0);
      chk32("mid_rst_data", data_o, '0);
      step();
      rstn = 1'b1;
      @(negedge clk);
      chk1("mid_rst_in_ready", in_ready, 1'b1);
      chk1("mid_rst_req_after", req_o, 1'b0);
      step();

      // Every accepted word completed except the one cut short by reset
      chkn("final_done_count", n_done, n_acc - 1);
      chkn("final_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
